// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter: shares one byte-wide UART transmit sink between NUM_SRC
// byte-stream sources. The round-robin grant is held for a whole message,
// up to and including the tlast byte, so messages never interleave at the
// sink. The sink side is a single registered output stage.
// Optional feature: define ARB_TIMEOUT_EN to revoke a grant whose owner has
// been idle mid-message for TIMEOUT_CYCLES cycles (pulses o_timeout).
module uart_msg_arbiter #(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [8*NUM_SRC-1:0]   i_tdata,
    input  logic [NUM_SRC-1:0]     i_tlast,
    input  logic [NUM_SRC-1:0]     i_tvalid,
    output logic [NUM_SRC-1:0]     o_tready,
    output logic [NUM_SRC-1:0]     o_grant,
    output logic [7:0]             o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   i_tready,
    output logic                   o_timeout
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    // Reject illegal parameter sets at elaboration
    if (NUM_SRC < 2 || NUM_SRC > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_msg_arbiter: NUM_SRC must be 2..16 and TIMEOUT_CYCLES >= 1");
    end

    state_t             r_state;
    logic [NUM_SRC-1:0] r_grant;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_ptr;
    logic [7:0]         r_tdata;
    logic               r_tlast;
    logic               r_tvalid;

    logic               w_any;
    logic [IDX_W-1:0]   w_pick;
    logic               w_slot_free;
    logic               w_gvalid;
    logic               w_glast;
    logic [7:0]         w_gdata;
    logic               w_accept;
    logic               w_sink_xfer;

    // Output register can take a byte when empty or draining this cycle
    assign w_slot_free = !r_tvalid || i_tready;
    assign o_tready    = (r_state == ST_XFER && w_slot_free) ? r_grant : '0;

    assign w_gvalid    = i_tvalid[r_gidx];
    assign w_glast     = i_tlast[r_gidx];
    assign w_gdata     = i_tdata[{r_gidx, 3'b000} +: 8];
    assign w_accept    = (r_state == ST_XFER) && w_slot_free && w_gvalid;
    assign w_sink_xfer = r_tvalid && i_tready;

    assign o_grant  = r_grant;
    assign o_tdata  = r_tdata;
    assign o_tlast  = r_tlast;
    assign o_tvalid = r_tvalid;

    // Round-robin pick: first requester after r_ptr, wrapping modulo NUM_SRC
    always_comb begin
        w_any  = |i_tvalid;
        w_pick = r_ptr;
        for (int k = int'(NUM_SRC); k >= 1; k--) begin
            if (i_tvalid[IDX_W'((32'(r_ptr) + 32'(k)) % NUM_SRC)]) begin
                w_pick = IDX_W'((32'(r_ptr) + 32'(k)) % NUM_SRC);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_timeout;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

    // Arbitration FSM, output register and optional idle-owner timeout
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_ptr    <= IDX_W'(NUM_SRC - 1);
            r_tdata  <= 8'h00;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            if (w_accept) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_gdata;
                r_tlast  <= w_glast;
            end else if (w_sink_xfer) begin
                r_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_XFER;
                        r_gidx  <= w_pick;
                        r_grant <= NUM_SRC'(1) << w_pick;
`ifdef ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                ST_XFER: begin
                    if (w_accept) begin
`ifdef ARB_TIMEOUT_EN
                        r_cnt <= '0;
`endif
                        if (w_glast) begin
                            r_ptr   <= r_gidx;
                            r_grant <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (!w_gvalid) begin
                        // This idle cycle brings the count to TIMEOUT_CYCLES
                        if (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                            r_timeout <= 1'b1;
                            r_ptr     <= r_gidx;
                            r_grant   <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Testbench for uart_msg_arbiter: directed scenarios followed by a randomized
// phase, all checked cycle by cycle against a behavioural model that tracks
// the current owner, rr pointer and output slot as plain integers, plus a
// sink-side scoreboard for message contiguity, per-source order and byte count.
module tb_uart_msg_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned T = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [8*N-1:0]   tdata;
    logic [N-1:0]     tlast;
    logic [N-1:0]     tvalid;
    logic [N-1:0]     o_tready;
    logic [N-1:0]     o_grant;
    logic [7:0]       o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             tready;
    logic             o_timeout;

    always #5 clk = ~clk;

    uart_msg_arbiter #(.NUM_SRC(N), .TIMEOUT_CYCLES(T)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_tdata  (tdata),
        .i_tlast  (tlast),
        .i_tvalid (tvalid),
        .o_tready (o_tready),
        .o_grant  (o_grant),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .i_tready (tready),
        .o_timeout(o_timeout)
    );

    int total = 0;
    int bad   = 0;

    // model state
    int         m_owner, m_ptr, m_cnt;
    logic       m_ov, m_ol, m_oend, m_to;
    logic [7:0] m_od;

    // source byte queues {tlast, data}
    logic [8:0] smem [N][128];
    int         shead [N];
    int         stail [N];
    bit         held  [N];
    bit         gap_en, rdy_rand, seq_chk;
    logic       rdy_val;
    int         cyc;

    // sink scoreboard
    logic [8:0] sink_q[$];
    int         sink_cyc[$];
    int         glog[$];
    int         sink_src;
    int         next_seq [N];
    int         acc_cyc, to_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = int'(N) - 1; m_cnt = 0;
        m_ov = 0; m_ol = 0; m_oend = 0; m_to = 0; m_od = 8'h00;
        sink_src = -1;
    endtask

    task automatic clear_src();
        for (int k = 0; k < N; k++) begin shead[k] = 0; stail[k] = 0; held[k] = 0; end
    endtask

    task automatic clear_logs();
        sink_q.delete(); sink_cyc.delete(); glog.delete();
        acc_cyc = -1; to_cyc = -1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        smem[k][stail[k]] = {l, d};
        stail[k]++;
    endtask

    // present source heads (AXI-style: a raised valid is held until accepted)
    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (shead[k] < stail[k]) begin
                tvalid[k]     = !gap_en || held[k] || ($urandom_range(3) != 0);
                tdata[8*k +: 8] = smem[k][shead[k]][7:0];
                tlast[k]      = smem[k][shead[k]][8];
            end else begin
                tvalid[k]     = 1'b0;
                tdata[8*k +: 8] = 8'($urandom);
                tlast[k]      = 1'($urandom);
            end
        end
        tready = rdy_rand ? ($urandom_range(3) != 0) : rdy_val;
    endtask

    task automatic sink_take(input logic [7:0] b, input logic is_end);
        if (sink_src >= 0) chk("contig", 32'(b[7:6]), 32'(sink_src));
        if (seq_chk) begin
            chk("order", 32'(b[5:0]), 32'(next_seq[b[7:6]]));
            next_seq[b[7:6]]++;
        end
        sink_src = is_end ? -1 : int'(b[7:6]);
        sink_q.push_back({is_end, b});
        sink_cyc.push_back(cyc);
    endtask

    // compare this cycle's outputs with the model, then advance one clock
    task automatic step();
        logic [N-1:0] eg, etr;
        bit free, acc, xfer, found;
        int idx;
        @(negedge clk);
        eg   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        free = !m_ov || tready;
        etr  = free ? eg : '0;
        chk("grant",   32'(o_grant),   32'(eg));
        chk("tready",  32'(o_tready),  32'(etr));
        chk("tvalid",  32'(o_tvalid),  32'(m_ov));
        chk("tdata",   32'(o_tdata),   32'(m_od));
        chk("tlast",   32'(o_tlast),   32'(m_ol));
        chk("timeout", 32'(o_timeout), 32'(m_to));

        acc  = (m_owner >= 0) && free && tvalid[m_owner];
        xfer = m_ov && tready;
        for (int k = 0; k < N; k++) begin
            held[k] = tvalid[k] && !(acc && m_owner == k);
            if (acc && m_owner == k) shead[k]++;
        end

        if (rst) begin
            model_reset();
        end else begin
            if (xfer) sink_take(m_od, m_ol || m_oend);
            m_to = 0;
            if (acc) begin
                m_ov = 1; m_od = tdata[8*m_owner +: 8]; m_ol = tlast[m_owner]; m_oend = 0;
                acc_cyc = cyc;
            end else if (xfer) begin
                m_ov = 0;
            end
            if (m_owner < 0) begin
                found = 0;
                for (int j = 1; j <= int'(N); j++) begin
                    idx = (m_ptr + j) % int'(N);
                    if (!found && tvalid[idx]) begin
                        found = 1; m_owner = idx; m_cnt = 0; glog.push_back(idx);
                    end
                end
            end else if (acc) begin
                m_cnt = 0;
                if (tlast[m_owner]) begin m_ptr = m_owner; m_owner = -1; end
            end
`ifdef ARB_TIMEOUT_EN
            else if (!tvalid[m_owner]) begin
                if (m_cnt + 1 == int'(T)) begin
                    m_to = 1; m_ptr = m_owner; m_owner = -1; to_cyc = cyc + 1;
                    // truncated message: its last byte may still be in the slot
                    if (m_ov) m_oend = 1; else sink_src = -1;
                end else begin
                    m_cnt++;
                end
            end
`endif
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin drive(); step(); end
    endtask

    task automatic do_reset();
        clear_src();
        rst = 1'b1; drive(); step(); rst = 1'b0;
        clear_src(); clear_logs();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nbytes, guard, seq, len;
        bit pend;
        rst = 1'b1; tvalid = '0; tdata = '0; tlast = '0; tready = 1'b1;
        gap_en = 0; rdy_rand = 0; rdy_val = 1'b1; seq_chk = 0; cyc = 0;
        for (int k = 0; k < N; k++) next_seq[k] = 0;
        clear_src(); clear_logs(); model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant",   32'(o_grant),   32'(0));
        chk("rst_tready",  32'(o_tready),  32'(0));
        chk("rst_tvalid",  32'(o_tvalid),  32'(0));
        chk("rst_tdata",   32'(o_tdata),   32'(0));
        chk("rst_timeout", 32'(o_timeout), 32'(0));
        rst = 1'b0;

        // 1: single message from src1
        push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
        drive(); step();
        chk("t1_grant", 32'(o_grant), 32'h2);
        run(6);
        chk("t1_count", 32'(sink_q.size()), 32'(3));
        chk("t1_b0", 32'(sink_q[0]), 32'h041);
        chk("t1_b1", 32'(sink_q[1]), 32'h042);
        chk("t1_b2", 32'(sink_q[2]), 32'h143);
        chk("t1_lat", 32'(sink_cyc[0]), 32'(2));
        chk("t1_back2back", 32'(sink_cyc[2] - sink_cyc[0]), 32'(2));

        // 2: src0 and src2 contend, src0 first, one bubble between messages
        do_reset();
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
        push(2, 8'h81, 1'b0); push(2, 8'h82, 1'b1);
        run(10);
        chk("t2_glog_n", 32'(glog.size()), 32'(2));
        chk("t2_first", 32'(glog[0]), 32'(0));
        chk("t2_second", 32'(glog[1]), 32'(2));
        chk("t2_b2", 32'(sink_q[2]), 32'h081);
        chk("t2_bubble", 32'(sink_cyc[2] - sink_cyc[1]), 32'(2));

        // 3: all sources request, 1-byte messages, rotating order
        do_reset();
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < N; k++) push(k, 8'((k << 6) | m), 1'b1);
        run(20);
        for (int i = 0; i < 5; i++) chk("t3_order", 32'(glog[i]), 32'(i % 4));
        for (int i = 0; i < 4; i++) chk("t3_gap", 32'(sink_cyc[i+1] - sink_cyc[i]), 32'(2));

        // 4: sink stalls 5 cycles mid-message
        do_reset();
        push(2, 8'h90, 1'b0); push(2, 8'h91, 1'b0); push(2, 8'h92, 1'b0); push(2, 8'h93, 1'b1);
        run(3);
        rdy_val = 1'b0;
        repeat (5) begin
            drive(); step();
            chk("t4_hold_data",  32'(o_tdata),  32'h91);
            chk("t4_hold_valid", 32'(o_tvalid), 32'(1));
            chk("t4_tready",     32'(o_tready), 32'(0));
        end
        rdy_val = 1'b1;
        run(8);
        chk("t4_count", 32'(sink_q.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            chk("t4_bytes", 32'(sink_q[i]), 32'({(i == 3), 8'(8'h90 + i)}));

        // 5: reset mid-message drops the pending byte, src0 regains priority
        do_reset();
        push(3, 8'hC0, 1'b0); push(3, 8'hC1, 1'b0); push(3, 8'hC2, 1'b0); push(3, 8'hC3, 1'b1);
        run(3);
        rst = 1'b1; drive(); step(); rst = 1'b0;
        chk("t5_tvalid", 32'(o_tvalid), 32'(0));
        chk("t5_grant",  32'(o_grant),  32'(0));
        clear_src(); clear_logs();
        push(3, 8'hC5, 1'b1); push(0, 8'h05, 1'b1);
        drive(); step();
        chk("t5_prio", 32'(o_grant), 32'h1);
        run(8);
        chk("t5_second", 32'(glog[1]), 32'(3));

        // 6: owner src3 goes idle mid-message while src0 waits
        do_reset();
        push(3, 8'hC7, 1'b0);
        drive(); step();
        push(0, 8'h07, 1'b1);
`ifdef ARB_TIMEOUT_EN
        run(14);
        // T idle cycles after the accept cycle, then the registered pulse
        chk("t6_to_dist", 32'(to_cyc - acc_cyc), 32'(T + 1));
        chk("t6_glog_n", 32'(glog.size()), 32'(2));
        chk("t6_next", 32'(glog[1]), 32'(0));
`else
        run(30);
        chk("t6_hold", 32'(o_grant), 32'h8);
        chk("t6_no_to", 32'(o_timeout), 32'(0));
        push(3, 8'hC8, 1'b1);
        run(6);
        chk("t6_next", 32'(glog[1]), 32'(0));
`endif

        // random phase: gappy sources, random sink backpressure
        do_reset();
        gap_en = 1; rdy_rand = 1; seq_chk = 1; nbytes = 0;
        for (int k = 0; k < N; k++) begin
            next_seq[k] = 0; seq = 0;
            for (int m = 0; m < 6; m++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    push(k, 8'((k << 6) | seq), b == len - 1);
                    seq++; nbytes++;
                end
            end
        end
        guard = 0;
        pend = 1;
        while (pend && guard < 4000) begin
            drive(); step(); guard++;
            pend = m_ov;
            for (int k = 0; k < N; k++) if (shead[k] < stail[k]) pend = 1;
        end
        chk("rand_drain", 32'(guard < 4000), 32'(1));
        chk("rand_bytes", 32'(sink_q.size()), 32'(nbytes));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
